// File: rtl/mmul_seq_pkg.sv
// Shared types for the systolic matrix-multiply command sequencer.
package mmul_seq_pkg;

  localparam int DEF_ADDR_WIDTH = 64;
  localparam int DEF_KT_WIDTH   = 8;

  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

  typedef enum logic {
    MMUL_D  = 1'b0,  // multiply then drain C
    MMUL_ND = 1'b1   // multiply and keep accumulating in the array
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } mseq_state_t;

  // Array skew (T_D) and drain length (T_C) for an NxN array.
  function automatic int t_d(input int n);
    return 2 * n;
  endfunction

  function automatic int t_c(input int n);
    return n;
  endfunction

endpackage

// File: rtl/mseq_addr_gen.sv
// Base register plus strided offset incrementer; addr_o = base + offset (mod 2^ADDR_WIDTH).
module mseq_addr_gen #(
  parameter int          ADDR_WIDTH = 64,
  parameter int unsigned STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic                  step_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH-1:0] offset_o
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRIDE);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] off_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      off_q  <= '0;
    end else if (clear_i) begin
      base_q <= '0;
      off_q  <= '0;
    end else if (load_i) begin
      base_q <= base_i;
      off_q  <= '0;
    end else if (step_i) begin
      off_q  <= off_q + STEP;
    end
  end

  assign addr_o   = base_q + off_q;
  assign offset_o = off_q;

endmodule

// File: rtl/mmul_seq.sv
// Command sequencer: feeds A/B operand addresses, waits out the array skew, then drains C rows.
module mmul_seq
  import mmul_seq_pkg::*;
#(
  parameter int N          = 2,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int KT_WIDTH   = DEF_KT_WIDTH,
  parameter int ELEM_BYTES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  cmd_t                  cmd_i,
  input  logic [ADDR_WIDTH-1:0] a_base_i,
  input  logic [ADDR_WIDTH-1:0] b_base_i,
  input  logic [ADDR_WIDTH-1:0] c_base_i,
  input  logic [KT_WIDTH-1:0]   k_tiles_i,
  input  logic                  abort_i,
  output logic                  feed_valid_o,
  input  logic                  feed_ready_i,
  output logic [ADDR_WIDTH-1:0] a_addr_o,
  output logic [ADDR_WIDTH-1:0] b_addr_o,
  output logic                  feed_last_o,
  output logic                  drain_en_o,
  output logic [ADDR_WIDTH-1:0] c_addr_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int          BW        = KT_WIDTH + $clog2(N);
  localparam int          FLUSH_LEN = t_d(N) - 1;
  localparam int          FW        = $clog2(t_d(N));
  localparam int unsigned STRIDE    = N * ELEM_BYTES;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW_OFF = ADDR_WIDTH'((t_c(N) - 1) * STRIDE);

  mseq_state_t           state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [KT_WIDTH-1:0]   k_q, k_d;
  logic [ADDR_WIDTH-1:0] b_base_q, b_base_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [FW-1:0]         flush_q, flush_d;

  logic                  accept;
  logic [BW-1:0]         last_beat;
  logic                  ab_clear, ab_load, ab_step;
  logic                  c_clear, c_load, c_step;
  logic [ADDR_WIDTH-1:0] a_addr, ab_off, c_addr, c_off;

  assign accept    = cmd_valid_i && (state_q == IDLE);
  assign last_beat = BW'(k_q) * BW'(N) - BW'(1);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    k_d      = k_q;
    b_base_d = b_base_q;
    beat_d   = beat_q;
    flush_d  = flush_q;
    ab_clear = 1'b0;
    ab_load  = 1'b0;
    ab_step  = 1'b0;
    c_clear  = 1'b0;
    c_load   = 1'b0;
    c_step   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d    = cmd_i;
          k_d      = k_tiles_i;
          b_base_d = b_base_i;
          ab_load  = 1'b1;
          c_load   = 1'b1;
          state_d  = (k_tiles_i == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (feed_ready_i) begin
          if (beat_q == last_beat) begin
            beat_d  = '0;
            state_d = FLUSH;
          end else begin
            beat_d  = beat_q + BW'(1);
            ab_step = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (flush_q == FW'(FLUSH_LEN - 1)) begin
          flush_d = '0;
          state_d = (cmd_q == MMUL_D) ? DRAIN : DONE;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      DRAIN: begin
        // The C row index lives in the generator offset; the final row ends the drain.
        if (c_off == LAST_ROW_OFF) begin
          c_clear = 1'b1;
          state_d = DONE;
        end else begin
          c_step  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_i && (state_q != IDLE)) begin
      state_d  = IDLE;
      beat_d   = '0;
      flush_d  = '0;
      ab_clear = 1'b1;
      c_clear  = 1'b1;
      ab_step  = 1'b0;
      c_step   = 1'b0;
    end
  end

  // NOTE: asynchronous active-low reset returns the FSM and all counters to zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= MMUL_D;
      k_q      <= '0;
      b_base_q <= '0;
      beat_q   <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      k_q      <= k_d;
      b_base_q <= b_base_d;
      beat_q   <= beat_d;
      flush_q  <= flush_d;
    end
  end

  mseq_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRIDE     (STRIDE)
  ) u_ab_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (ab_clear),
    .load_i   (ab_load),
    .base_i   (a_base_i),
    .step_i   (ab_step),
    .addr_o   (a_addr),
    .offset_o (ab_off)
  );

  mseq_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRIDE     (STRIDE)
  ) u_c_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (c_clear),
    .load_i   (c_load),
    .base_i   (c_base_i),
    .step_i   (c_step),
    .addr_o   (c_addr),
    .offset_o (c_off)
  );

  // Outputs decode registered state only; addresses read zero outside their valid window.
  assign cmd_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign feed_valid_o = (state_q == FEED);
  assign feed_last_o  = feed_valid_o && (beat_q == last_beat);
  assign a_addr_o     = feed_valid_o ? a_addr : '0;
  assign b_addr_o     = feed_valid_o ? (b_base_q + ab_off) : '0;
  assign drain_en_o   = (state_q == DRAIN);
  assign c_addr_o     = drain_en_o ? c_addr : '0;

endmodule

// File: tb/tb_mmul_seq.sv
// Self-checking bench for mmul_seq: queue-based transaction model plus directed literal checks.
module tb_mmul_seq;
  import mmul_seq_pkg::*;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int KW = 8;
  localparam int EB = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  cmd_t          cmd_i = MMUL_D;
  logic [AW-1:0] a_base_i = '0, b_base_i = '0, c_base_i = '0;
  logic [KW-1:0] k_tiles_i = '0;
  logic          abort_i = 1'b0;
  logic          feed_valid_o;
  logic          feed_ready_i = 1'b1;
  logic [AW-1:0] a_addr_o, b_addr_o, c_addr_o;
  logic          feed_last_o, drain_en_o, busy_o, done_o;

  always #5 clk = ~clk;

  mmul_seq #(.N(N), .ADDR_WIDTH(AW), .KT_WIDTH(KW), .ELEM_BYTES(EB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_i        (cmd_i),
    .a_base_i     (a_base_i),
    .b_base_i     (b_base_i),
    .c_base_i     (c_base_i),
    .k_tiles_i    (k_tiles_i),
    .abort_i      (abort_i),
    .feed_valid_o (feed_valid_o),
    .feed_ready_i (feed_ready_i),
    .a_addr_o     (a_addr_o),
    .b_addr_o     (b_addr_o),
    .feed_last_o  (feed_last_o),
    .drain_en_o   (drain_en_o),
    .c_addr_o     (c_addr_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic          last;
  } beat_t;

  beat_t         exp_feed[$];
  logic [AW-1:0] exp_drain[$];
  int            exp_done = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected transaction stream of one command, straight from the address rules.
  task automatic model_cmd(input cmd_t c, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] cb, input int k);
    for (int i = 0; i < k * N; i++) begin
      beat_t t;
      t.a    = a + AW'(i * N * EB);
      t.b    = b + AW'(i * N * EB);
      t.last = (i == k * N - 1);
      exp_feed.push_back(t);
    end
    if (c == MMUL_D && k > 0)
      for (int r = 0; r < N; r++) exp_drain.push_back(cb + AW'(r * N * EB));
    exp_done++;
  endtask

  task automatic model_flush();
    exp_feed.delete();
    exp_drain.delete();
    exp_done = 0;
  endtask

  // Compare process: every cycle out of reset, outputs must match the model stream.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_vs_busy", cmd_ready_o, !busy_o);
      if (feed_valid_o) begin
        if (exp_feed.size() == 0) check("feed_unexpected", feed_valid_o, 0);
        else begin
          check("feed_a", a_addr_o, exp_feed[0].a);
          check("feed_b", b_addr_o, exp_feed[0].b);
          check("feed_last", feed_last_o, exp_feed[0].last);
          if (feed_ready_i) void'(exp_feed.pop_front());
        end
      end else begin
        check("last_without_valid", feed_last_o, 0);
      end
      if (drain_en_o) begin
        if (exp_drain.size() == 0) check("drain_unexpected", drain_en_o, 0);
        else check("drain_c", c_addr_o, exp_drain.pop_front());
      end
      if (done_o) begin
        check("done_expected", exp_done > 0, 1);
        check("done_feed_left", exp_feed.size(), 0);
        check("done_drain_left", exp_drain.size(), 0);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic issue(input cmd_t c, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] cb, input int k);
    check("cmd_ready_before_issue", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_i       = c;
    a_base_i    = a;
    b_base_i    = b;
    c_base_i    = cb;
    k_tiles_i   = KW'(k);
    model_cmd(c, a, b, cb, k);
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    cmd_valid_i = 1'b0;
  endtask

  // Latency is the cycle index (accept cycle = 0) in which done_o is seen.
  task automatic wait_done(input string name, input int exp_lat);
    int lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_o) begin
        lat = cyc - acc_cyc + 1;
        break;
      end
    end
    check(name, lat, exp_lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    #3;
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_feed_valid", feed_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_drain", drain_en_o, 0);
    check("rst_a_addr", a_addr_o, 0);
    check("rst_c_addr", c_addr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MMUL_D, k=1: literal timeline
    issue(MMUL_D, 64'h100, 64'h200, 64'h300, 1);
    @(negedge clk);
    check("t1_c1_a", a_addr_o, 64'h100);
    check("t1_c1_b", b_addr_o, 64'h200);
    check("t1_c1_last", feed_last_o, 0);
    @(negedge clk);
    check("t1_c2_a", a_addr_o, 64'h102);
    check("t1_c2_b", b_addr_o, 64'h202);
    check("t1_c2_last", feed_last_o, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_flush_fv", feed_valid_o, 0);
      check("t1_flush_drain", drain_en_o, 0);
      check("t1_flush_busy", busy_o, 1);
    end
    @(negedge clk);
    check("t1_c6_drain", drain_en_o, 1);
    check("t1_c6_c", c_addr_o, 64'h300);
    @(negedge clk);
    check("t1_c7_c", c_addr_o, 64'h302);
    check("t1_c7_done", done_o, 0);
    @(negedge clk);
    check("t1_c8_done", done_o, 1);
    @(posedge clk);
    #1;

    // MMUL_ND, k=2: 4 beats, 3 flush, done, no drain
    issue(MMUL_ND, 64'h100, 64'h200, 64'h300, 2);
    wait_done("lat_nd_k2", 8);

    // Stall 3 cycles on beat 1
    issue(MMUL_D, 64'h100, 64'h200, 64'h300, 2);
    @(negedge clk);
    @(posedge clk);
    #1;
    feed_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_fv", feed_valid_o, 1);
      check("stall_a", a_addr_o, 64'h102);
      check("stall_last", feed_last_o, 0);
    end
    @(posedge clk);
    #1;
    feed_ready_i = 1'b1;
    wait_done("lat_stall", 13);

    // k_tiles=0: done next cycle, nothing else
    issue(MMUL_D, 64'h400, 64'h500, 64'h600, 0);
    wait_done("lat_k0", 1);

    // Abort during DRAIN row 0, then immediate new command
    issue(MMUL_D, 64'h100, 64'h200, 64'h300, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (drain_en_o) begin
        seen = 1;
        break;
      end
    end
    check("abort_reach_drain", seen, 1);
    check("abort_row0_c", c_addr_o, 64'h300);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    model_flush();
    check("abort_drain_low", drain_en_o, 0);
    check("abort_no_done", done_o, 0);
    check("abort_idle", busy_o, 0);
    issue(MMUL_ND, 64'h700, 64'h800, 64'h900, 1);
    wait_done("lat_after_abort", 6);

    // Address wrap
    issue(MMUL_D, 64'hFFFF_FFFF_FFFF_FFFE, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    @(negedge clk);
    check("wrap_a0", a_addr_o, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    check("wrap_a1", a_addr_o, 64'h0);
    wait_done("lat_wrap", 8);

    // Asynchronous reset during FEED
    issue(MMUL_D, 64'h100, 64'h200, 64'h300, 2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_flush();
    check("mid_rst_ready", cmd_ready_o, 1);
    check("mid_rst_fv", feed_valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_a", a_addr_o, 0);
    check("mid_rst_last", feed_last_o, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(MMUL_ND, 64'h100, 64'h200, 64'h300, 1);
    wait_done("lat_after_reset", 6);

    check("end_feed_left", exp_feed.size(), 0);
    check("end_drain_left", exp_drain.size(), 0);
    check("end_done_left", exp_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmul_seq.md
Name: mmul_seq

Overview:
- Parametrised command sequencer for the NxN systolic matrix-multiply array.
- Accepts one MMUL_D (multiply then drain) or MMUL_ND (multiply and keep accumulating) command at a time.
- Generates A/B operand feed addresses with a last-beat flag, waits out the array skew, then, for MMUL_D only, generates C drain addresses with drain enable.
- Sits between the host command interface and the operand/result memories; it generalises the fixed compute_req/drain_en control word to variable N and K.

Parameters:
N, 2, systolic array dimension (SYS_ARRAY_SIZE); must be >= 2
ADDR_WIDTH, 64, address width (addr_t)
KT_WIDTH, 8, width of the k_tiles field
ELEM_BYTES, 1, bytes per element (DATA_WIDTH/8)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_i? no: cmd_ready_o  out  1  command accepted when valid&ready
cmd_i  in  cmd_t  MMUL_D or MMUL_ND
a_base_i  in  ADDR_WIDTH  A operand base address
b_base_i  in  ADDR_WIDTH  B operand base address
c_base_i  in  ADDR_WIDTH  C result base address
k_tiles_i  in  KT_WIDTH  number of NxN K-tiles; 0 is legal
abort_i  in  1  synchronous abort
feed_valid_o  out  1  A/B feed beat valid
feed_ready_i  in  1  memory accepts the beat
a_addr_o  out  ADDR_WIDTH  A address for the beat
b_addr_o  out  ADDR_WIDTH  B address for the beat
feed_last_o  out  1  final feed beat (drives matrix_data_t.last)
drain_en_o  out  1  drain row valid
c_addr_o  out  ADDR_WIDTH  C row address
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state is IDLE;
  - all counters are 0;
  - all outputs are 0 except cmd_ready_o=1.
- FSM states: IDLE, FEED, FLUSH, DRAIN, DONE.
- Outputs are registered from state and counters; no combinational path from inputs to outputs except none.
- cmd_ready_o=1 only in IDLE. On cmd_valid_i&cmd_ready_o, cmd, bases and k_tiles are latched in the same cycle.
- IDLE, on accept:
  - k_tiles=0 -> DONE (no feed, no drain);
  - otherwise -> FEED.
- FEED:
  - Beats total = k_tiles*N, beat index b = 0..k_tiles*N-1.
  - feed_valid_o=1.
  - a_addr_o = a_base + b*N*ELEM_BYTES; b_addr_o = b_base + b*N*ELEM_BYTES.
  - b advances only on feed_valid_o&feed_ready_i. With feed_ready_i=0, addresses and last are held stable.
  - feed_last_o=1 only when b is the final beat.
  - The handshake of the final beat moves the FSM to FLUSH.
- FLUSH:
  - Lasts exactly T_D-1 = 2N-1 cycles; feed_valid_o=0.
  - Then -> DRAIN if MMUL_D, -> DONE if MMUL_ND.
- DRAIN:
  - Lasts T_C = N cycles, row r = 0..N-1, unconditional (no stall).
  - drain_en_o=1; c_addr_o = c_base + r*N*ELEM_BYTES.
  - -> DONE after r=N-1.
- DONE: done_o=1 for one cycle -> IDLE.
- abort_i=1 in any non-IDLE state:
  - next cycle is IDLE with all counters cleared;
  - feed_valid_o and drain_en_o are 0 from that cycle;
  - no done_o pulse.
  - abort_i in IDLE has no effect. If abort_i and an accept coincide in IDLE, the accept wins.
- Address arithmetic is modulo 2^ADDR_WIDTH; base+offset wrap silently.
- Beat counter is KT_WIDTH+$clog2(N) bits wide, so the maximum k_tiles does not overflow.
- Reset asserted mid-operation: immediate return to the reset values above. Any in-flight beat is dropped.

Decomposition:
- common_pkg gains:
  - mseq_state_t enum {IDLE, FEED, FLUSH, DRAIN, DONE};
  - mseq_cmd_t packed struct {cmd_t cmd; addr_t a_base, b_base, c_base; logic[KT_WIDTH-1:0] k_tiles};
  - KT_WIDTH.
- Reused from common_pkg: cmd_t, addr_t, T_D, T_C.
- One sub-module, mseq_addr_gen: a base register plus a strided incrementer with load/step/clear controls. It is instantiated twice, once for the shared A/B beat index and once for the C row index.

Test Plan:
- N=2, MMUL_D, k=1, bases A=0x100 B=0x200 C=0x300, feed_ready=1, accept at cycle 0 -> expected response:
  - feed at cycles 1-2 with A 0x100/0x102 and B 0x200/0x202, last at cycle 2;
  - FLUSH cycles 3-5;
  - drain at cycles 6-7 with C 0x300/0x302;
  - done at cycle 8.
- N=2, MMUL_ND, k=2 -> 4 beats with A 0x100..0x106, last only on beat 3, 3 FLUSH cycles, done, drain_en_o never asserted.
- Stall: feed_ready_i=0 for 3 cycles on beat 1 -> a_addr_o held at 0x102 and feed_last_o held 0; the total sequence is 3 cycles longer.
- k_tiles=0, MMUL_D -> done_o the cycle after accept; no feed_valid_o, no drain_en_o.
- abort_i during DRAIN row 0 -> IDLE next cycle, drain_en_o drops, no done_o; a new command is accepted the following cycle.
- Wrap and reset: a_base=0xFFFF_FFFF_FFFF_FFFE with k=1 gives A addresses ...FFFE then 0x0. rst_n pulsed low during FEED -> outputs go to reset values asynchronously and cmd_ready_o=1.
